// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding and sizing.
// Optional feature macro: DIV_ZERO_FAST_EN (adds the DIVZERO short-cut state).
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        DIVZERO = 2'd1,
`endif
        ON      = 2'd2,
        END     = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder, trial-subtracts the divisor in WIDTH+1 bits and keeps
// the difference only when it is non-negative.
module div_step
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // Trial subtraction; the sign bit of the WIDTH+1-bit difference decides.
    always_comb begin
        partial = {rem_i, dvd_bit_i};
        diff    = partial - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the execute stage (DIV / DIVU).
// Handshake: start_i is held high by the requester until ready_o; ready_o is a
// single-cycle pulse with result_o valid in the same cycle; stall_o asks the
// pipeline to hold while a request is outstanding; annul_i abandons any work.
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero finishes in 2 cycles).
module div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o,
    output div_state_e         dbg_state_o
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor magnitude
    logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;   // quotient bits collected so far
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     step_rem;
    logic                 step_q;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        ready_o   = 1'b0;
        result_o  = result_q;
        quo_fix   = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix   = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    quo_neg_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rem_neg_d = signed_i & opdata1_i[WIDTH-1];
                    dvd_d     = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
                    dvs_d     = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == '0)
                        state_d = DIVZERO;
                    else
`endif
                        state_d = ON;
                end
            end
`ifdef DIV_ZERO_FAST_EN
            DIVZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    // Zero result: clear magnitudes and signs so END emits 0.
                    rem_d     = '0;
                    quo_d     = '0;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    state_d   = END;
                end
            end
`endif
            ON: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_q};
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT)
                        state_d = END;
                end
            end
            END: begin
                // Leaves unconditionally; an annul only suppresses the result.
                state_d = IDLE;
                if (!annul_i) begin
                    ready_o  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                    result_o = result_d;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_o = rst & start_i & ~ready_o & ~annul_i;
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized bench for div_unit, checked against an arithmetic
// reference model. Build with DIV_ZERO_FAST_EN to match the fast-zero variant.
module tb_div_unit;
    import mips_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;
    div_state_e  dbg_state_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .annul_i     (annul_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_o     (stall_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder
    // follows the dividend), plus the divide-by-zero rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'd0;
`else
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
            return {r, q};
`endif
        end
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
        return {r, q};
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Issues one request, scrambles operands while busy, checks result,
    // latency, stall behaviour and the single-cycle ready pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [63:0] exp, input string tag);
        int lat;
        int stall_bad;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        lat       = -1;
        stall_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = c;
                break;
            end
            if (!stall_o) stall_bad++;
            @(posedge clk); #1;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom_range(0, 1));
        end
        last_exp = exp_q.pop_front();
        check({tag, "/latency"}, 64'(lat), 64'(exp_latency(b)));
        check({tag, "/result"}, result_o, last_exp);
        check({tag, "/stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "/stall_ready"}, 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "/ready_pulse"}, 64'(ready_o), 64'd0);
        check({tag, "/hold"}, result_o, last_exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          ready_seen;

        rst       = 1'b0;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        #12;
        check("reset/result", result_o, 64'd0);
        check("reset/ready", 64'(ready_o), 64'd0);
        check("reset/stall", 64'(stall_o), 64'd0);
        check("reset/state", 64'(dbg_state_o), 64'(IDLE));
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "u100_7");
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, "s_min_m1");
`ifdef DIV_ZERO_FAST_EN
        run_op(32'd5, 32'd0, 1'b0, 64'd0, "u5_0");
`else
        run_op(32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, "u5_0");
`endif
        run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "u100_7b");

        // Annul in cycle 10 of 100 / 7.
        @(posedge clk); #1;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check("annul/ready", 64'(ready_o), 64'd0);
        check("annul/stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("annul/state", 64'(dbg_state_o), 64'(IDLE));
        check("annul/result", result_o, last_exp);
        ready_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check("annul/no_ready", 64'(ready_seen), 64'd0);
        check("annul/result_late", result_o, last_exp);
        run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "u9_3");

        // Reset in cycle 15 of an operation.
        @(posedge clk); #1;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid/result", result_o, 64'd0);
        check("rst_mid/ready", 64'(ready_o), 64'd0);
        check("rst_mid/stall", 64'(stall_o), 64'd0);
        check("rst_mid/state", 64'(dbg_state_o), 64'(IDLE));
        last_exp = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(32'd20, 32'd4, 1'b0, {32'd0, 32'd5}, "u20_4");

        // Randomized operands, signedness and divisor classes.
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = ~32'($urandom_range(0, 14));
                default: rb = 32'($urandom);
            endcase
            run_op(ra, rb, rs, ref_div(ra, rb, rs), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
